// File: rtl/dom_tree_builder.sv
// dom_tree_builder: turns element tag parser events into a flat DOM node
// stream. Keeps an open-element stack of {tag, id}, hands out sequential node
// IDs, tags attributes with the element being parsed, and raises sticky
// nesting error flags.
module dom_tree_builder #(
  parameter int TAG_W       = 3,
  parameter int ATYPE_W     = 4,
  parameter int AVAL_W      = 16,
  parameter int STACK_DEPTH = 8,
  parameter int ID_W        = 6,
  parameter int VOID_TAG    = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               element_done,
  input  logic [TAG_W-1:0]                   element_tag,
  input  logic                               element_type,
  input  logic                               has_attribute,
  input  logic [ATYPE_W-1:0]                 attribute_type,
  input  logic [AVAL_W-1:0]                  attribute_value,
  output logic                               node_valid,
  output logic [ID_W-1:0]                    node_id,
  output logic [ID_W-1:0]                    node_parent,
  output logic [TAG_W-1:0]                   node_tag,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   node_depth,
  output logic                               attr_valid,
  output logic [ID_W-1:0]                    attr_node,
  output logic [ATYPE_W-1:0]                 attr_type,
  output logic [AVAL_W-1:0]                  attr_value,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               doc_done,
  output logic                               err_mismatch,
  output logic                               err_overflow,
  output logic                               err_underflow
);

  localparam int DW = $clog2(STACK_DEPTH+1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [ID_W-1:0]  ROOT_ID = {ID_W{1'b1}};
  localparam logic [TAG_W-1:0] VOID    = TAG_W'(VOID_TAG);
  localparam logic [DW-1:0]    MAXD    = DW'(STACK_DEPTH);

  // edge-detect history and builder state
  logic              r_done_q, r_attr_q;
  logic [DW-1:0]     r_depth;
  logic [ID_W-1:0]   r_next_id;
  logic [TAG_W-1:0]  r_stk_tag [STACK_DEPTH];
  logic [ID_W-1:0]   r_stk_id  [STACK_DEPTH];

  // registered outputs
  logic              r_node_valid, r_attr_valid, r_doc_done;
  logic [ID_W-1:0]   r_node_id, r_node_parent, r_attr_node;
  logic [TAG_W-1:0]  r_node_tag;
  logic [DW-1:0]     r_node_depth;
  logic [ATYPE_W-1:0] r_attr_type;
  logic [AVAL_W-1:0] r_attr_value;
  logic              r_err_mis, r_err_ovf, r_err_unf;

  logic              w_elem_ev, w_attr_ev, w_void;
  logic [IW-1:0]     w_push_idx, w_top_idx;
  logic [TAG_W-1:0]  w_top_tag;
  logic [ID_W-1:0]   w_top_id;
  logic              w_emit, w_push, w_pop, w_done;
  logic              w_set_mis, w_set_ovf, w_set_unf;

  assign w_elem_ev  = element_done & ~r_done_q;
  assign w_attr_ev  = has_attribute & ~r_attr_q;
  assign w_void     = (element_tag == VOID);
  assign w_push_idx = IW'(r_depth);
  assign w_top_idx  = IW'(r_depth - DW'(1));
  assign w_top_tag  = r_stk_tag[w_top_idx];
  assign w_top_id   = r_stk_id[w_top_idx];

  // decode one element event into push/pop/emit/error actions
  always_comb begin
    w_emit    = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_done    = 1'b0;
    w_set_mis = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (w_elem_ev) begin
      if (!element_type) begin
        // out of IDs, or no room to push a non-void element: drop it
        if (r_next_id == ROOT_ID)
          w_set_ovf = 1'b1;
        else if (!w_void && r_depth == MAXD)
          w_set_ovf = 1'b1;
        else begin
          w_emit = 1'b1;
          w_push = !w_void;
        end
      end else if (!w_void) begin
        if (r_depth == '0)
          w_set_unf = 1'b1;
        else begin
          // pop even on a tag mismatch so the stack keeps draining
          w_pop     = 1'b1;
          w_set_mis = (w_top_tag != element_tag);
          w_done    = (r_depth == DW'(1));
        end
      end
    end
  end

  // edge-detect registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_done_q <= 1'b0;
      r_attr_q <= 1'b0;
    end else begin
      r_done_q <= element_done;
      r_attr_q <= has_attribute;
    end
  end

  // open-element stack, depth and ID counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_depth   <= '0;
      r_next_id <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_stk_tag[i] <= '0;
        r_stk_id[i]  <= '0;
      end
    end else begin
      if (w_emit)
        r_next_id <= r_next_id + ID_W'(1);
      if (w_push) begin
        r_stk_tag[w_push_idx] <= element_tag;
        r_stk_id[w_push_idx]  <= r_next_id;
        r_depth               <= r_depth + DW'(1);
      end else if (w_pop) begin
        r_depth <= r_depth - DW'(1);
      end
    end
  end

  // output records and sticky error flags; data fields hold between pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_node_valid  <= 1'b0;
      r_node_id     <= '0;
      r_node_parent <= '0;
      r_node_tag    <= '0;
      r_node_depth  <= '0;
      r_attr_valid  <= 1'b0;
      r_attr_node   <= '0;
      r_attr_type   <= '0;
      r_attr_value  <= '0;
      r_doc_done    <= 1'b0;
      r_err_mis     <= 1'b0;
      r_err_ovf     <= 1'b0;
      r_err_unf     <= 1'b0;
    end else begin
      r_node_valid <= w_emit;
      if (w_emit) begin
        r_node_id     <= r_next_id;
        r_node_parent <= (r_depth == '0) ? ROOT_ID : w_top_id;
        r_node_tag    <= element_tag;
        r_node_depth  <= r_depth;
      end
      // attribute belongs to the element being parsed: pre-increment ID
      r_attr_valid <= w_attr_ev;
      if (w_attr_ev) begin
        r_attr_node  <= r_next_id;
        r_attr_type  <= attribute_type;
        r_attr_value <= attribute_value;
      end
      r_doc_done <= w_done;
      r_err_mis  <= r_err_mis | w_set_mis;
      r_err_ovf  <= r_err_ovf | w_set_ovf;
      r_err_unf  <= r_err_unf | w_set_unf;
    end
  end

  assign node_valid    = r_node_valid;
  assign node_id       = r_node_id;
  assign node_parent   = r_node_parent;
  assign node_tag      = r_node_tag;
  assign node_depth    = r_node_depth;
  assign attr_valid    = r_attr_valid;
  assign attr_node     = r_attr_node;
  assign attr_type     = r_attr_type;
  assign attr_value    = r_attr_value;
  assign depth         = r_depth;
  assign doc_done      = r_doc_done;
  assign err_mismatch  = r_err_mis;
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;

endmodule
